// File: rtl/mfp_ahb_sevensegn_if.sv
// mfp_ahb_sevensegn_if: AHB-Lite signal bundle between the bus fabric and the seven-segment slave
interface mfp_ahb_sevensegn_if;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic [31:0] HRDATA;
   logic        HREADYOUT;
   logic        HRESP;
   modport master (output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
                   input HRDATA, HREADYOUT, HRESP);
   modport slave (input HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
                  output HRDATA, HREADYOUT, HRESP);
endinterface

// File: rtl/mfp_ahb_sevensegn.sv
// mfp_ahb_sevensegn: AHB-Lite slave scanning an N-digit common-anode seven-segment display with PWM dimming and leading-zero blanking
module mfp_ahb_sevensegn #(
   parameter int N_DIGITS    = 8,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                HCLK,
   input  logic                SI_Reset,
   mfp_ahb_sevensegn_if.slave  ahb,
   output logic [N_DIGITS-1:0] disenout,
   output logic [7:0]          disout
);
   localparam int PW = $clog2(REFRESH_DIV);
   localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic                dp_valid, dp_write, dp_word;
   logic [2:0]          dp_addr;
   logic [N_DIGITS-1:0] en, dp;
   logic [31:0]         val_lo, val_hi, rdata;
   logic                lzb;
   logic [3:0]          bright, idx, ph, nib;
   logic [PW-1:0]       pre;
   logic [63:0]         vals;
   logic [15:0]         en16, dp16, blank16;
   logic                nz, wr_en, on;
   logic                unused_ok;
   assign ahb.HREADYOUT = 1'b1;
   assign ahb.HRESP     = 1'b0;
   assign wr_en = dp_valid & dp_write & dp_word;
   assign vals  = {val_hi, val_lo};
   assign en16  = 16'(en);
   assign dp16  = 16'(dp);
   assign nib   = vals[{idx, 2'b00} +: 4];
   assign on    = en16[idx] & (ph <= bright);
   assign unused_ok = &{1'b0, ahb.HADDR[31:5], ahb.HADDR[1:0], ahb.HTRANS[0], vals};
   assign rdata = dp_addr == 3'd0 ? 32'(en) :
                  dp_addr == 3'd1 ? val_lo :
                  dp_addr == 3'd2 ? val_hi :
                  dp_addr == 3'd3 ? 32'(dp) :
                  dp_addr == 3'd4 ? {24'h0, bright, 3'h0, lzb} :
                  dp_addr == 3'd5 ? {28'h0, idx} : 32'h0;
   assign ahb.HRDATA = (dp_valid & ~dp_write) ? rdata : 32'h0;
   // Capture the accepted address phase so the data phase knows what to do
   always_ff @(posedge HCLK or posedge SI_Reset)
      if (SI_Reset) begin
         dp_valid <= 1'b0;
         dp_write <= 1'b0;
         dp_word  <= 1'b0;
         dp_addr  <= 3'd0;
      end else begin
         dp_valid <= ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY;
         if (ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY) begin
            dp_write <= ahb.HWRITE;
            dp_word  <= ahb.HSIZE == 3'b010;
            dp_addr  <= ahb.HADDR[4:2];
         end
      end
   // Word writes land in the addressed register at the close of the data phase
   always_ff @(posedge HCLK or posedge SI_Reset)
      if (SI_Reset) begin
         en     <= '0;
         dp     <= '0;
         val_lo <= 32'h0;
         val_hi <= 32'h0;
         lzb    <= 1'b0;
         bright <= 4'hF;
      end else if (wr_en) begin
         if (dp_addr == 3'd0) en <= ahb.HWDATA[N_DIGITS-1:0];
         if (dp_addr == 3'd1) val_lo <= ahb.HWDATA;
         if (dp_addr == 3'd2 && N_DIGITS > 8) val_hi <= ahb.HWDATA;
         if (dp_addr == 3'd3) dp <= ahb.HWDATA[N_DIGITS-1:0];
         if (dp_addr == 3'd4) begin
            lzb    <= ahb.HWDATA[0];
            bright <= ahb.HWDATA[7:4];
         end
      end
   // Digit k blanks when no enabled digit at or above it holds a nonzero value
   always_comb begin
      nz      = 1'b0;
      blank16 = '0;
      for (int k = N_DIGITS - 1; k >= 0; k--) begin
         nz         = nz | (en[k] & (vals[4*k +: 4] != 4'h0));
         blank16[k] = lzb & ~nz & (k != 0);
      end
   end
   // Prescaler sets the slot length; the PWM phase free-runs every cycle
   always_ff @(posedge HCLK or posedge SI_Reset)
      if (SI_Reset) begin
         pre <= '0;
         idx <= 4'd0;
         ph  <= 4'd0;
      end else begin
         ph <= ph + 4'd1;
         if (pre == PW'(REFRESH_DIV - 1)) begin
            pre <= '0;
            idx <= (idx == 4'(N_DIGITS - 1)) ? 4'd0 : idx + 4'd1;
         end else
            pre <= pre + PW'(1);
      end
   // Register the pins one cycle behind the scan state
   always_ff @(posedge HCLK or posedge SI_Reset)
      if (SI_Reset) begin
         disenout <= '1;
         disout   <= 8'hFF;
      end else begin
         disenout <= on ? ~(N_DIGITS'(1) << idx) : '1;
         disout   <= on ? {~dp16[idx], blank16[idx] ? 7'h7F : HEX[nib]} : 8'hFF;
      end
endmodule
